mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Purpose: round-robin arbiter that shares the 4:1 datapath multiplexer among four requesters by driving its select pair (s1, s0) and a one-hot grant.

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum cycles an owner keeps the grant while another requester waits; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  request vector; bit i requests mux input i.
REQ-005 grant  output  4  one-hot grant; all-zero when no owner.
REQ-006 s1  output  1  mux select MSB (owner index bit 1).
REQ-007 s0  output  1  mux select LSB (owner index bit 0).
REQ-008 busy  output  1  high while grant is non-zero.
REQ-009 The block SHALL use one clock (clk) and one reset (rst_n); reset is asynchronous and active-low.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from req to any output.

Function
REQ-011 The controller SHALL implement exactly three states: IDLE, OWN, RELEASE.
REQ-012 The controller SHALL keep a 2-bit last pointer (last owner index) and an 8-bit hold counter cnt.
REQ-013 Arbitration SHALL pick the first asserted req bit scanning (last+1), (last+2), (last+3), (last+4) mod 4.
REQ-014 IDLE: if req != 0, the next edge SHALL enter OWN with grant[w]=1, {s1,s0}=w, busy=1, cnt=0, where w is the winner; otherwise remain in IDLE.
REQ-015 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to grant visible.
REQ-016 OWN: cnt SHALL increment each cycle, saturating at HOLD_MAX-1.
REQ-017 OWN: if req[owner]=0, the next edge SHALL enter RELEASE.
REQ-018 OWN: if cnt==HOLD_MAX-1 and any other req bit is 1, the next edge SHALL enter RELEASE (preemption).
REQ-019 OWN: if neither REQ-017 nor REQ-018 applies, the controller SHALL stay in OWN with outputs unchanged.
REQ-020 OWN with only the owner requesting SHALL hold the grant indefinitely; cnt stays saturated.
REQ-021 Entering RELEASE SHALL set grant=0, busy=0, last=owner; {s1,s0} SHALL hold the previous owner index (no select glitch).
REQ-022 RELEASE lasts exactly one cycle: if req != 0, arbitrate per REQ-013 into OWN; otherwise go to IDLE.
REQ-023 A preempted owner still requesting SHALL receive lowest priority in the following arbitration.
REQ-024 Requests asserting or deasserting in the same cycle as a release SHALL be sampled in the RELEASE cycle only.
REQ-025 At most one grant bit SHALL ever be high; grant SHALL be zero for at least one cycle between any two owners.

Reset
REQ-026 While rst_n=0: state=IDLE, grant=0000, s1=0, s0=0, busy=0, last=3, cnt=0, so index 0 has first priority after reset.
REQ-027 Reset asserted mid-ownership SHALL clear grant and busy immediately (asynchronously), with no RELEASE cycle.
REQ-028 Reset deassertion SHALL take effect on the first rising clk edge after rst_n rises; a req sampled on that edge SHALL be granted on the following edge.

Verification
REQ-029 Reset, then req=0001 held: grant=0001, {s1,s0}=00, busy=1 one cycle after the first sampled edge; grant is held indefinitely.
REQ-030 req=1111 continuously, HOLD_MAX=8: owners rotate 0,1,2,3,0; each owns 8 cycles, followed by 1 zero-grant cycle.
REQ-031 Owner 2 drops req after 3 cycles while req=1010: RELEASE cycle with {s1,s0}=10 held, then grant=1000, {s1,s0}=11.
REQ-032 Owner 1 holding, req[3] rises at cnt=2: no preemption until cnt=7, then RELEASE, then grant=1000.
REQ-033 rst_n pulsed low while grant=0100: grant=0000 and busy=0 with no clock; after release with req=0100, grant=0100 returns after 1 cycle.
REQ-034 Assertion check across all tests: grant is one-hot or zero, busy==(grant!=0), and {s1,s0}==index(grant) whenever busy=1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 datapath mux.
// Drives the mux select pair {s1,s0} and a one-hot grant.
// Every output comes straight from a flop, so req never reaches an output combinationally.
// After any owner the grant drops to zero for one RELEASE cycle.
// During that cycle the select lines keep the previous owner index, so the mux never glitches.

module mux_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       s1,
   output logic       s0,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      RELEASE = 2'd2
   } arbState_e;

   // Highest value the hold counter reaches; it saturates here while the owner keeps the grant.
   localparam logic [7:0] CntMax = 8'(HOLD_MAX - 1);

   arbState_e  state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic [1:0] last_q, last_d;
   logic [7:0] cnt_q, cnt_d;

   logic [1:0] winner;
   logic [1:0] scanIdx;
   logic       winnerFound;
   logic       anyReq;
   logic       ownerReq;
   logic       othersReq;
   logic       cntSat;

   // Rotating priority scan.
   // Start just after the last owner and wrap modulo 4.
   // The last owner is therefore considered only after everyone else.
   always_comb begin
      winner      = 2'd0;
      winnerFound = 1'b0;
      scanIdx     = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         scanIdx = last_q + k[1:0];
         if (!winnerFound && req[scanIdx]) begin
            winner      = scanIdx;
            winnerFound = 1'b1;
         end
      end
   end

   // Request qualifiers used by the state machine.
   // In OWN, sel_q holds the owner index and grant_q holds the owner's one-hot bit.
   always_comb begin
      anyReq    = |req;
      ownerReq  = req[sel_q];
      othersReq = |(req & ~grant_q);
      cntSat    = (cnt_q == CntMax);
   end

   // State register and all output/bookkeeping flops.
   // Reset leaves last_q = 3 so that index 0 gets first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 4'b0000;
         sel_q   <= 2'd0;
         busy_q  <= 1'b0;
         last_q  <= 2'd3;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   // An owner leaves OWN when it drops its request.
   // It is also preempted once its hold time is used up and someone else is waiting.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (anyReq) state_d = OWN;
         end
         OWN: begin
            if (!ownerReq || (cntSat && othersReq)) state_d = RELEASE;
         end
         RELEASE: begin
            state_d = anyReq ? OWN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered-output next values.
   // The select pair only changes when a new owner is installed.
   // Through RELEASE and IDLE it keeps the previous owner index.
   always_comb begin
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RELEASE: begin
            if (state_d == OWN) begin
               grant_d = 4'b0001 << winner;
               sel_d   = winner;
               busy_d  = 1'b1;
               cnt_d   = 8'd0;
            end else begin
               grant_d = 4'b0000;
               busy_d  = 1'b0;
               cnt_d   = 8'd0;
            end
         end
         OWN: begin
            if (state_d == RELEASE) begin
               grant_d = 4'b0000;
               busy_d  = 1'b0;
               last_d  = sel_q;
               cnt_d   = 8'd0;
            end else if (!cntSat) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign grant = grant_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter with the default HOLD_MAX of 8.
// Inputs change on the falling edge, and outputs are compared on the falling edge.
// Each compare also checks that grant is one-hot or zero and that busy and the select lines agree with grant.

module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant;
   logic       s1;
   logic       s0;
   logic       busy;

   int checks;
   int errors;

   mux_rr_arbiter #(.HOLD_MAX(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .grant (grant),
      .s1    (s1),
      .s0    (s0),
      .busy  (busy)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] indexOf(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = i[1:0];
      return r;
   endfunction

   task automatic applyStimulus(input logic [3:0] r);
      req = r;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                              input logic [1:0] expSel, input logic expBusy);
      logic [1:0] selNow;
      selNow = {s1, s0};
      checks++;
      assert (grant === expGrant) else begin
         errors++;
         $error("[TB] FAIL %s grant got %b want %b", tag, grant, expGrant);
      end
      checks++;
      assert (selNow === expSel) else begin
         errors++;
         $error("[TB] FAIL %s sel got %b want %b", tag, selNow, expSel);
      end
      checks++;
      assert (busy === expBusy) else begin
         errors++;
         $error("[TB] FAIL %s busy got %b want %b", tag, busy, expBusy);
      end
      checks++;
      assert ($onehot0(grant)) else begin
         errors++;
         $error("[TB] FAIL %s onehot0 grant got %b want onehot-or-zero", tag, grant);
      end
      checks++;
      assert (busy === (grant != 4'b0000)) else begin
         errors++;
         $error("[TB] FAIL %s busy-vs-grant got busy=%b want %b", tag, busy, (grant != 4'b0000));
      end
      if (busy === 1'b1) begin
         checks++;
         assert (selNow === indexOf(grant)) else begin
            errors++;
            $error("[TB] FAIL %s sel-vs-grant got %b want %b", tag, selNow, indexOf(grant));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = 4'b0000;

      // Reset state.
      stepCycles(2);
      checkOutput("reset", 4'b0000, 2'b00, 1'b0);

      // Release reset with req 0001. Grant should appear one cycle later and stay.
      rst_n = 1'b1;
      applyStimulus(4'b0001);
      stepCycles(1);
      checkOutput("first_grant", 4'b0001, 2'b00, 1'b1);
      for (int i = 0; i < 20; i++) begin
         stepCycles(1);
         checkOutput("hold_sole", 4'b0001, 2'b00, 1'b1);
      end

      // All requesting: owner 0 is saturated, so it is preempted at once.
      // Then 1,2,3,0 each own for 8 cycles, separated by one zero-grant cycle.
      applyStimulus(4'b1111);
      stepCycles(1);
      checkOutput("rot_rel0", 4'b0000, 2'b00, 1'b0);
      for (int o = 1; o <= 4; o++) begin
         logic [1:0] own;
         own = o[1:0];
         for (int c = 0; c < 8; c++) begin
            stepCycles(1);
            checkOutput("rot_own", 4'b0001 << own, own, 1'b1);
         end
         if (o == 4) applyStimulus(4'b0000);
         stepCycles(1);
         checkOutput("rot_rel", 4'b0000, own, 1'b0);
      end
      stepCycles(1);
      checkOutput("rot_idle", 4'b0000, 2'b00, 1'b0);

      // Owner 2 drops its request after 3 cycles while 1 and 3 wait.
      // Expect a RELEASE cycle that keeps sel=10, then owner 3.
      applyStimulus(4'b0100);
      stepCycles(1);
      checkOutput("o2_grant", 4'b0100, 2'b10, 1'b1);
      applyStimulus(4'b1110);
      stepCycles(2);
      checkOutput("o2_cnt2", 4'b0100, 2'b10, 1'b1);
      applyStimulus(4'b1010);
      stepCycles(1);
      checkOutput("o2_release", 4'b0000, 2'b10, 1'b0);
      stepCycles(1);
      checkOutput("o3_grant", 4'b1000, 2'b11, 1'b1);
      applyStimulus(4'b0000);
      stepCycles(1);
      checkOutput("o3_release", 4'b0000, 2'b11, 1'b0);
      stepCycles(1);
      checkOutput("o3_idle", 4'b0000, 2'b11, 1'b0);

      // Owner 1 holds; req[3] rises at cnt=2. There is no preemption until cnt=7.
      applyStimulus(4'b0010);
      stepCycles(1);
      checkOutput("o1_cnt0", 4'b0010, 2'b01, 1'b1);
      stepCycles(2);
      checkOutput("o1_cnt2", 4'b0010, 2'b01, 1'b1);
      applyStimulus(4'b1010);
      for (int c = 3; c <= 7; c++) begin
         stepCycles(1);
         checkOutput("o1_hold", 4'b0010, 2'b01, 1'b1);
      end
      stepCycles(1);
      checkOutput("o1_preempt", 4'b0000, 2'b01, 1'b0);
      stepCycles(1);
      checkOutput("o3_after_pre", 4'b1000, 2'b11, 1'b1);

      // Move ownership to index 2, then pulse reset mid-cycle with no clock edge.
      applyStimulus(4'b0100);
      stepCycles(1);
      checkOutput("o3_drop", 4'b0000, 2'b11, 1'b0);
      stepCycles(1);
      checkOutput("o2_again", 4'b0100, 2'b10, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 4'b0000, 2'b00, 1'b0);
      stepCycles(1);
      rst_n = 1'b1;
      stepCycles(1);
      checkOutput("post_reset", 4'b0100, 2'b10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
